// File: rtl/dcache_port_arbiter_if.sv
// Request/response bus shared by the pipeline ports and the D-cache core.
// master drives requests and consumes responses; slave acks requests and returns responses.
interface dcache_port_arbiter_if #(
    parameter int DATA_W = 64,
    parameter int TAG_W  = 13
);
    logic              reqcyc;
    logic [DATA_W-1:0] req;
    logic [TAG_W-1:0]  reqtag;
    logic              reqack;
    logic              respcyc;
    logic [DATA_W-1:0] resp;
    logic              respack;

    modport master (
        output reqcyc, req, reqtag, respack,
        input  reqack, respcyc, resp
    );

    modport slave (
        input  reqcyc, req, reqtag, respack,
        output reqack, respcyc, resp
    );
endinterface

// File: rtl/dcache_port_arbiter.sv
// Round-robin arbiter sharing the D-cache core bus between the M (load) and W (store) ports,
// granting one whole transaction at a time with a single transaction outstanding.
module dcache_port_arbiter #(
    parameter int DATA_W   = 64,
    parameter int TAG_W    = 13,
    parameter int WR_BEATS = 9,
    parameter int RD_BEATS = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    dcache_port_arbiter_if.slave   m,
    dcache_port_arbiter_if.slave   w,
    dcache_port_arbiter_if.master  c,
    output logic [1:0]             grant
);

    localparam int MAX_BEATS = (WR_BEATS > RD_BEATS) ? WR_BEATS : RD_BEATS;
    localparam int CNT_W     = $clog2(MAX_BEATS + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_RESP
    } state_t;

    state_t           state;
    logic             last_w;
    logic             is_read;
    logic [CNT_W-1:0] count;
    logic             pick_m;
    logic             own_m;
    logic             own_w;

    // On contention the port that did not own the previous transaction wins.
    assign pick_m = m.reqcyc & (~w.reqcyc | last_w);
    assign own_m  = grant[1];
    assign own_w  = grant[0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= S_IDLE;
            grant   <= '0;
            last_w  <= 1'b1;
            is_read <= 1'b0;
            count   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (m.reqcyc || w.reqcyc) begin
                        grant   <= pick_m ? 2'b10 : 2'b01;
                        is_read <= pick_m ? m.reqtag[0] : w.reqtag[0];
                        count   <= '0;
                        state   <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (c.reqcyc && c.reqack) begin
                        if (is_read) begin
                            count <= '0;
                            state <= S_RESP;
                        end else if (count == CNT_W'(WR_BEATS - 1)) begin
                            last_w <= grant[0];
                            grant  <= '0;
                            count  <= '0;
                            state  <= S_IDLE;
                        end else begin
                            count <= count + 1'b1;
                        end
                    end
                end
                S_RESP: begin
                    if (c.respcyc && c.respack) begin
                        if (count == CNT_W'(RD_BEATS - 1)) begin
                            last_w <= grant[0];
                            grant  <= '0;
                            count  <= '0;
                            state  <= S_IDLE;
                        end else begin
                            count <= count + 1'b1;
                        end
                    end
                end
                default: begin
                    grant <= '0;
                    count <= '0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        c.reqcyc  = 1'b0;
        c.req     = '0;
        c.reqtag  = '0;
        c.respack = 1'b0;
        m.reqack  = 1'b0;
        m.respcyc = 1'b0;
        m.resp    = '0;
        w.reqack  = 1'b0;
        w.respcyc = 1'b0;
        w.resp    = '0;
        if (state == S_REQ) begin
            if (own_m) begin
                c.reqcyc = m.reqcyc;
                c.req    = m.req;
                c.reqtag = m.reqtag;
                m.reqack = c.reqack;
            end else if (own_w) begin
                c.reqcyc = w.reqcyc;
                c.req    = w.req;
                c.reqtag = w.reqtag;
                w.reqack = c.reqack;
            end
        end else if (state == S_RESP) begin
            // Data fans out to both ports; only the owner sees a valid strobe.
            m.resp = c.resp;
            w.resp = c.resp;
            if (own_m) begin
                m.respcyc = c.respcyc;
                c.respack = m.respack;
            end else if (own_w) begin
                w.respcyc = c.respcyc;
                c.respack = w.respack;
            end
        end
    end

    a_respcyc_in_resp: assert property (@(posedge clk) disable iff (!reset)
        c.respcyc |-> (state == S_RESP))
        else $fatal(1, "c_respcyc asserted outside RESP");

    a_reqack_in_req: assert property (@(posedge clk) disable iff (!reset)
        c.reqack |-> (state == S_REQ))
        else $fatal(1, "c_reqack asserted outside REQ");

    a_grant_onehot: assert property (@(posedge clk) disable iff (!reset)
        (state != S_IDLE) |-> $onehot(grant))
        else $fatal(1, "grant not one-hot while busy");

endmodule

// File: tb/tb_dcache_port_arbiter.sv
// Scoreboard bench for dcache_port_arbiter: requester drivers push expected cache beats and
// response words; negedge monitors pop and compare them as the DUT moves data.
module tb_dcache_port_arbiter;

    localparam int DATA_W   = 64;
    localparam int TAG_W    = 13;
    localparam int WR_BEATS = 9;
    localparam int RD_BEATS = 8;
    localparam int BEAT_W   = TAG_W + DATA_W;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic [1:0] grant;

    always #5 clk = ~clk;

    dcache_port_arbiter_if #(.DATA_W(DATA_W), .TAG_W(TAG_W)) m_if ();
    dcache_port_arbiter_if #(.DATA_W(DATA_W), .TAG_W(TAG_W)) w_if ();
    dcache_port_arbiter_if #(.DATA_W(DATA_W), .TAG_W(TAG_W)) c_if ();

    dcache_port_arbiter #(
        .DATA_W  (DATA_W),
        .TAG_W   (TAG_W),
        .WR_BEATS(WR_BEATS),
        .RD_BEATS(RD_BEATS)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .m    (m_if),
        .w    (w_if),
        .c    (c_if),
        .grant(grant)
    );

    int total = 0;
    int bad   = 0;
    int tag_seq = 0;

    logic [BEAT_W-1:0] cq_m[$];
    logic [BEAT_W-1:0] cq_w[$];
    logic [DATA_W-1:0] rq_m[$];
    logic [DATA_W-1:0] rq_w[$];
    logic [1:0]        grant_log[$];
    int                gap_log[$];
    int                idle_run = 0;
    logic [1:0]        prev_grant = 2'b00;
    logic [BEAT_W-1:0] mon_got;
    logic [BEAT_W-1:0] mon_exp;
    logic [DATA_W-1:0] mon_rexp;

    // Cache model: acks any presented beat while ack_en, streams RD_BEATS words after a read.
    logic ack_en  = 1'b1;
    logic resp_en = 1'b1;
    int   pending;

    assign c_if.reqack  = c_if.reqcyc & ack_en;
    assign c_if.respcyc = (pending != 0) && resp_en;
    assign c_if.resp    = 64'hA0 + 64'(RD_BEATS - pending);

    always @(posedge clk or negedge reset) begin
        if (!reset)
            pending <= 0;
        else if (c_if.reqcyc && c_if.reqack && c_if.reqtag[0])
            pending <= RD_BEATS;
        else if (c_if.respcyc && c_if.respack)
            pending <= pending - 1;
    end

    always @(negedge clk) begin
        if (reset) begin
            if (c_if.reqcyc && c_if.reqack) begin
                mon_got = {c_if.reqtag, c_if.req};
                total++;
                if (c_if.reqtag[TAG_W-1] ? (cq_w.size() == 0) : (cq_m.size() == 0)) begin
                    bad++;
                    $display("FAIL c_beat_unexpected got=%h exp=none", mon_got);
                end else begin
                    mon_exp = c_if.reqtag[TAG_W-1] ? cq_w.pop_front() : cq_m.pop_front();
                    if (mon_got !== mon_exp) begin
                        bad++;
                        $display("FAIL c_beat got=%h exp=%h", mon_got, mon_exp);
                    end
                end
                total++;
                if (grant !== (c_if.reqtag[TAG_W-1] ? 2'b01 : 2'b10)) begin
                    bad++;
                    $display("FAIL grant_at_beat got=%b exp=%b", grant,
                             c_if.reqtag[TAG_W-1] ? 2'b01 : 2'b10);
                end
            end
            if (m_if.respcyc) begin
                total++;
                if (rq_m.size() == 0) begin
                    bad++;
                    $display("FAIL m_respcyc_unexpected got=1 exp=0");
                end else if (m_if.respack) begin
                    mon_rexp = rq_m.pop_front();
                    if (m_if.resp !== mon_rexp) begin
                        bad++;
                        $display("FAIL m_resp got=%h exp=%h", m_if.resp, mon_rexp);
                    end
                end
            end
            if (w_if.respcyc) begin
                total++;
                if (rq_w.size() == 0) begin
                    bad++;
                    $display("FAIL w_respcyc_unexpected got=1 exp=0");
                end else if (w_if.respack) begin
                    mon_rexp = rq_w.pop_front();
                    if (w_if.resp !== mon_rexp) begin
                        bad++;
                        $display("FAIL w_resp got=%h exp=%h", w_if.resp, mon_rexp);
                    end
                end
            end
            if (m_if.reqack || w_if.reqack) begin
                total++;
                if (m_if.reqack && w_if.reqack) begin
                    bad++;
                    $display("FAIL dual_reqack got=11 exp=one");
                end
            end
            if (grant == 2'b00) begin
                idle_run++;
            end else if (prev_grant == 2'b00) begin
                grant_log.push_back(grant);
                gap_log.push_back(idle_run);
                idle_run = 0;
            end
            prev_grant = grant;
        end
    end

    task automatic set_req(input bit p, input logic cyc, input logic [DATA_W-1:0] d,
                           input logic [TAG_W-1:0] t);
        if (p) begin
            w_if.reqcyc = cyc; w_if.req = d; w_if.reqtag = t;
        end else begin
            m_if.reqcyc = cyc; m_if.req = d; m_if.reqtag = t;
        end
    endtask

    task automatic set_respack(input bit p, input logic v);
        if (p) w_if.respack = v;
        else   m_if.respack = v;
    endtask

    function automatic logic get_reqack(input bit p);
        return p ? w_if.reqack : m_if.reqack;
    endfunction

    function automatic logic get_respcyc(input bit p);
        return p ? w_if.respcyc : m_if.respcyc;
    endfunction

    function automatic logic get_respack(input bit p);
        return p ? w_if.respack : m_if.respack;
    endfunction

    task automatic clear_logs();
        grant_log.delete();
        gap_log.delete();
        idle_run = 0;
    endtask

    // One whole transaction from port p (0=M, 1=W); response beat stall_beat is held off stall_len cycles.
    task automatic txn(input bit p, input bit rd, input logic [DATA_W-1:0] base,
                       input int stall_beat, input int stall_len);
        logic [TAG_W-1:0] tag;
        int nb, cyc, got, stall_left;
        logic acked;
        tag_seq++;
        tag = {p, tag_seq[TAG_W-3:0], rd};
        nb  = rd ? 1 : WR_BEATS;
        for (int i = 0; i < nb; i++) begin
            if (p) cq_w.push_back({tag, base + 64'(i)});
            else   cq_m.push_back({tag, base + 64'(i)});
        end
        if (rd) begin
            for (int i = 0; i < RD_BEATS; i++) begin
                if (p) rq_w.push_back(64'hA0 + 64'(i));
                else   rq_m.push_back(64'hA0 + 64'(i));
            end
        end
        for (int i = 0; i < nb; i++) begin
            set_req(p, 1'b1, base + 64'(i), tag);
            cyc = 0;
            acked = 1'b0;
            while (!acked && cyc < 300) begin
                @(negedge clk);
                acked = get_reqack(p);
                @(posedge clk); #1;
                cyc++;
            end
            if (!acked) begin
                total++; bad++;
                $display("FAIL reqack_timeout port=%0d beat=%0d got=0 exp=1", p, i);
                set_req(p, 1'b0, '0, tag);
                return;
            end
        end
        set_req(p, 1'b0, '0, tag);
        if (rd) begin
            got = 0;
            cyc = 0;
            stall_left = stall_len;
            while (got < RD_BEATS && cyc < 300) begin
                if (got == stall_beat && stall_left > 0) begin
                    set_respack(p, 1'b0);
                    stall_left--;
                end else begin
                    set_respack(p, 1'b1);
                end
                @(negedge clk);
                total++;
                if (c_if.respack !== get_respack(p)) begin
                    bad++;
                    $display("FAIL c_respack_mirror got=%b exp=%b", c_if.respack, get_respack(p));
                end
                if (get_respcyc(p) && get_respack(p)) got++;
                @(posedge clk); #1;
                cyc++;
            end
            set_respack(p, 1'b0);
            if (got != RD_BEATS) begin
                total++; bad++;
                $display("FAIL resp_timeout port=%0d got=%0d exp=%0d", p, got, RD_BEATS);
            end
        end
    endtask

    task automatic check_drained(input string name);
        total++;
        if ((cq_m.size() + cq_w.size() + rq_m.size() + rq_w.size()) !== 0) begin
            bad++;
            $display("FAIL %s_drained got=%0d/%0d/%0d/%0d exp=0/0/0/0", name,
                     cq_m.size(), cq_w.size(), rq_m.size(), rq_w.size());
        end
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        set_req(1'b0, 1'b0, '0, '0);
        set_req(1'b1, 1'b0, '0, '0);
        set_respack(1'b0, 1'b0);
        set_respack(1'b1, 1'b0);
        ack_en = 1'b1;
        resp_en = 1'b1;
        cq_m.delete(); cq_w.delete(); rq_m.delete(); rq_w.delete();
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        set_req(1'b0, 1'b1, 64'h55, 13'h1);
        set_req(1'b1, 1'b1, 64'h66, 13'h1);
        set_respack(1'b0, 1'b1);
        set_respack(1'b1, 1'b1);
        repeat (2) begin
            @(negedge clk);
            total++;
            if ({grant, c_if.reqcyc, c_if.respack, m_if.reqack, m_if.respcyc, w_if.reqack,
                 w_if.respcyc} !== 8'b0) begin
                bad++;
                $display("FAIL reset_outputs got=%b%b%b%b%b%b%b exp=00000000", grant, c_if.reqcyc,
                         c_if.respack, m_if.reqack, m_if.respcyc, w_if.reqack, w_if.respcyc);
            end
        end
        apply_reset();
        @(negedge clk);
        total++;
        if ({grant, c_if.reqcyc} !== 3'b000) begin
            bad++;
            $display("FAIL idle_after_reset got=%b%b exp=000", grant, c_if.reqcyc);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_m_read();
        clear_logs();
        fork
            txn(1'b0, 1'b1, 64'h1000, -1, 0);
            begin
                @(negedge clk);
                total++;
                if ({grant, c_if.reqcyc} !== 3'b000) begin
                    bad++;
                    $display("FAIL arb_latency_idle got=%b%b exp=000", grant, c_if.reqcyc);
                end
                @(negedge clk);
                total++;
                if ({grant, c_if.reqcyc, c_if.req, c_if.reqtag[0]} !== {2'b10, 1'b1, 64'h1000, 1'b1}) begin
                    bad++;
                    $display("FAIL arb_latency_req got=%b %b %h exp=10 1 1000", grant, c_if.reqcyc, c_if.req);
                end
            end
        join
        @(negedge clk);
        total++;
        if ({grant, grant_log.size()} !== {2'b00, 32'd1} || grant_log[0] !== 2'b10) begin
            bad++;
            $display("FAIL m_read_grant got=%b n=%0d exp=00 n=1", grant, grant_log.size());
        end
        @(posedge clk); #1;
        check_drained("m_read");
    endtask

    task automatic test_simultaneous();
        int m_beats, w_early;
        apply_reset();
        clear_logs();
        m_beats = 0;
        w_early = 0;
        fork
            txn(1'b0, 1'b1, 64'h2000, -1, 0);
            txn(1'b1, 1'b0, 64'h3000, -1, 0);
            repeat (40) begin
                @(negedge clk);
                if (w_if.reqack && m_beats < RD_BEATS) w_early++;
                if (m_if.respcyc && m_if.respack) m_beats++;
            end
        join
        total++;
        if (w_early !== 0) begin
            bad++;
            $display("FAIL w_ack_before_m_done got=%0d exp=0", w_early);
        end
        total++;
        if (grant_log.size() !== 2 || grant_log[0] !== 2'b10 || grant_log[1] !== 2'b01) begin
            bad++;
            $display("FAIL simultaneous_order got=%0d:%b,%b exp=2:10,01", grant_log.size(),
                     grant_log[0], grant_log[1]);
        end
        check_drained("simultaneous");
    endtask

    task automatic test_back_to_back();
        clear_logs();
        fork
            begin
                txn(1'b0, 1'b1, 64'h4000, -1, 0);
                txn(1'b0, 1'b1, 64'h4100, -1, 0);
            end
            begin
                txn(1'b1, 1'b0, 64'h5000, -1, 0);
                txn(1'b1, 1'b0, 64'h5100, -1, 0);
            end
        join
        total++;
        if (grant_log.size() !== 4 || {grant_log[0], grant_log[1], grant_log[2], grant_log[3]} !== 8'b10011001) begin
            bad++;
            $display("FAIL b2b_order got=%0d:%b%b%b%b exp=4:10011001", grant_log.size(),
                     grant_log[0], grant_log[1], grant_log[2], grant_log[3]);
        end
        for (int i = 1; i < 4; i++) begin
            total++;
            if (gap_log[i] !== 1) begin
                bad++;
                $display("FAIL b2b_idle_gap idx=%0d got=%0d exp=1", i, gap_log[i]);
            end
        end
        check_drained("back_to_back");
    endtask

    task automatic test_ack_stall();
        int n, cyc;
        clear_logs();
        set_respack(1'b1, 1'b1);
        fork
            txn(1'b1, 1'b0, 64'h6000, -1, 0);
            begin
                n = 0;
                cyc = 0;
                while (n < 4 && cyc < 100) begin
                    @(negedge clk);
                    if (c_if.reqcyc && c_if.reqack) n++;
                    if (grant != 2'b00) begin
                        total++;
                        if (c_if.respack !== 1'b0) begin
                            bad++;
                            $display("FAIL write_respack got=1 exp=0");
                        end
                    end
                    cyc++;
                end
                if (n < 4) begin
                    total++; bad++;
                    $display("FAIL ack_stall_timeout got=%0d exp=4", n);
                end
                @(posedge clk); #1;
                ack_en = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    total++;
                    if ({c_if.reqcyc, c_if.req, w_if.reqack, c_if.respack} !== {1'b1, 64'h6004, 1'b0, 1'b0}) begin
                        bad++;
                        $display("FAIL ack_stall_hold got=%b %h %b %b exp=1 6004 0 0", c_if.reqcyc,
                                 c_if.req, w_if.reqack, c_if.respack);
                    end
                    @(posedge clk); #1;
                end
                ack_en = 1'b1;
            end
        join
        set_respack(1'b1, 1'b0);
        total++;
        if (grant_log.size() !== 1 || grant_log[0] !== 2'b01) begin
            bad++;
            $display("FAIL ack_stall_grant got=%0d:%b exp=1:01", grant_log.size(), grant_log[0]);
        end
        check_drained("ack_stall");
    endtask

    task automatic test_resp_stall();
        int k;
        k = 0;
        fork
            txn(1'b0, 1'b1, 64'h7000, 2, 2);
            repeat (20) begin
                @(negedge clk);
                if (m_if.respcyc) k++;
            end
        join
        total++;
        if (k !== RD_BEATS + 2) begin
            bad++;
            $display("FAIL resp_stall_cycles got=%0d exp=%0d", k, RD_BEATS + 2);
        end
        check_drained("resp_stall");
    endtask

    task automatic test_reset_mid();
        logic [TAG_W-1:0] tag;
        int got, cyc;
        logic acked;
        tag = {1'b0, 11'h7ff, 1'b1};
        cq_m.push_back({tag, 64'h8000});
        for (int i = 0; i < RD_BEATS; i++) rq_m.push_back(64'hA0 + 64'(i));
        set_req(1'b0, 1'b1, 64'h8000, tag);
        acked = 1'b0;
        cyc = 0;
        while (!acked && cyc < 50) begin
            @(negedge clk);
            acked = m_if.reqack;
            @(posedge clk); #1;
            cyc++;
        end
        set_req(1'b0, 1'b0, '0, tag);
        set_respack(1'b0, 1'b1);
        got = 0;
        cyc = 0;
        while (got < 3 && cyc < 50) begin
            @(negedge clk);
            if (m_if.respcyc && m_if.respack) got++;
            @(posedge clk); #1;
            cyc++;
        end
        total++;
        if ({m_if.respcyc, m_if.resp} !== {1'b1, 64'hA3}) begin
            bad++;
            $display("FAIL reset_mid_beat4 got=%b %h exp=1 a3", m_if.respcyc, m_if.resp);
        end
        #2 reset = 1'b0;
        #1;
        total++;
        if ({grant, c_if.reqcyc, c_if.respack, m_if.reqack, m_if.respcyc, m_if.resp, w_if.respcyc} !== '0) begin
            bad++;
            $display("FAIL reset_mid_async got=%b %b %b %b %b %h %b exp=all0", grant, c_if.reqcyc,
                     c_if.respack, m_if.reqack, m_if.respcyc, m_if.resp, w_if.respcyc);
        end
        apply_reset();
        clear_logs();
        txn(1'b1, 1'b0, 64'h9000, -1, 0);
        total++;
        if (grant_log.size() !== 1 || grant_log[0] !== 2'b01) begin
            bad++;
            $display("FAIL reset_mid_regrant got=%0d:%b exp=1:01", grant_log.size(), grant_log[0]);
        end
        check_drained("reset_mid");
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "simulation time limit");
    end

    initial begin
        set_req(1'b0, 1'b0, '0, '0);
        set_req(1'b1, 1'b0, '0, '0);
        set_respack(1'b0, 1'b0);
        set_respack(1'b1, 1'b0);
        test_reset();
        test_m_read();
        test_simultaneous();
        test_back_to_back();
        test_ack_stall();
        test_resp_stall();
        test_reset_mid();
        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dcache_port_arbiter.md
Name: dcache_port_arbiter

Overview:
- Shares the single data-cache core bus between two requesters: the Memory-stage load port (M) and the Writeback-stage store port (W).
- Grants one whole transaction at a time, using round-robin priority.
- Passes the request beats of the granted port through to the cache, and routes response beats back only to that port.
- Sits between the pipeline stages and the D-cache interface. Only one transaction is outstanding at a time.

Parameters:
- DATA_W, 64, width of req/resp words
- TAG_W, 13, width of reqtag; reqtag[0]=1 means READ, 0 means WRITE
- WR_BEATS, 9, request beats per write (address + 8 data words)
- RD_BEATS, 8, response beats per read

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- m_reqcyc  in  1  M request valid; held until m_reqack for each beat
- m_req  in  DATA_W  M address/data beat
- m_reqtag  in  TAG_W  M tag, stable for the whole transaction
- m_reqack  out  1  M beat accepted
- m_respcyc  out  1  M response beat valid
- m_resp  out  DATA_W  M response data
- m_respack  in  1  M consumed response beat
- w_reqcyc, w_req, w_reqtag, w_reqack, w_respcyc, w_resp, w_respack  same as M, for W
- c_reqcyc  out  1  to cache: request beat valid
- c_req  out  DATA_W  to cache: beat payload
- c_reqtag  out  TAG_W  to cache: tag
- c_reqack  in  1  cache accepted beat
- c_respcyc  in  1  cache response beat valid
- c_resp  in  DATA_W  cache response data
- c_respack  out  1  to cache: response beat consumed
- grant  out  2  one-hot owner {M,W}; 00 when idle

Behaviour:
Reset (reset=0, asynchronous):
- State=IDLE, grant=00, last=W (so M wins first), beat counter=0.
- All c_* and m_/w_ handshake outputs are 0.
- Reset mid-transaction abandons it silently; requesters must be reset too.

State IDLE:
- All pass-through outputs are 0.
- On a clock edge with any *_reqcyc=1, register the owner:
  - if only one port requests, it wins;
  - if both request, the port that is not `last` wins.
- Set grant, latch the owner's reqtag[0] into is_read, clear the counter, go to REQ.
- Arbitration costs exactly 1 cycle: a request seen at edge N appears on c_reqcyc during cycle N+1.

State REQ:
- Combinational pass-through: c_reqcyc/c_req/c_reqtag = owner's signals.
- owner_reqack = c_reqack; the non-owner's reqack stays 0.
- Each cycle with c_reqcyc & c_reqack counts one beat.
- Read: after 1 beat go to RESP.
- Write: after WR_BEATS beats, set last=owner, grant=00 and go to IDLE. Writes produce no response.

State RESP:
- owner_respcyc = c_respcyc; both m_resp and w_resp = c_resp; non-owner respcyc stays 0.
- c_respack = owner_respack.
- Each cycle with c_respcyc & c_respack counts one beat.
- After RD_BEATS beats, set last=owner, grant=00 and go to IDLE.

Other rules:
- The non-owner's requests are never acked while another transaction is in progress; they wait with reqcyc held.
- A requester dropping reqcyc mid-write stalls the transaction; the arbiter waits indefinitely and never times out.
- Both ports requesting on the same edge the arbiter returns to IDLE: this is normal round-robin, and the non-last port wins.
- A single requester re-requesting continuously is re-granted after 1 idle cycle.
- Assertions (simulation only), all fatal:
  - c_respcyc=1 outside RESP;
  - c_reqack=1 outside REQ;
  - grant not one-hot outside IDLE.
- Beat counter width is ceil(log2(max(WR_BEATS,RD_BEATS)+1)) and never wraps.

Test Plan:
1. M read only: m_reqcyc=1, tag[0]=1, req=0x1000 → c_req=0x1000 in cycle after arbitration; 8 resp beats 0xA0..0xA7 appear on m_resp with m_respcyc; w_respcyc stays 0; grant returns to 00.
2. Simultaneous first requests after reset (M read, W write) → M granted first (grant=10); W receives all 9 reqacks only after M's 8th respack; then grant=01.
3. Back-to-back contention, both holding reqcyc continuously for 4 transactions → grant order M,W,M,W, with one IDLE cycle between each.
4. W write where c_reqack is withheld for 3 cycles on beat 5 → beat count holds at 4, c_req stays at beat-5 data, completes after 9 acks; no c_respack ever asserted.
5. M read where m_respack is low for 2 cycles on beat 3 → c_respack mirrors it, beat count stalls, total 8 beats are still delivered.
6. Reset asserted during RESP beat 4 → all outputs 0 immediately (asynchronously); after release, a new W request is granted first, since last resets to W and only W requests.
